// File: rtl/motion_pkg.sv
// motion_pkg: shared types, default widths, Q-format helper, out_bus field offsets and the
// constant cosine generator that builds the heading table at elaboration time.
// Latency: n/a (no logic). Backpressure: n/a.
package motion_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROTATE,
    S_LOOKUP,
    S_STEP,
    S_CLAMP,
    S_PUBLISH
  } state_e;

  localparam int COORD_W_DEF    = 12;
  localparam int Z_W_DEF        = 8;
  localparam int DIR_W_DEF      = 10;
  localparam int ANGLE_BITS_DEF = 5;

  // Fractional bits of a direction component: Q1.(DIR_W-2), so 1.0 == 1 << (DIR_W-2).
  function automatic int q_frac(input int dir_w);
    return dir_w - 2;
  endfunction

  // out_bus = {dir_y, dir_x, pos_z, pos_y, pos_x}; pos_x sits at bit 0.
  function automatic int off_pos_y(input int cw);
    return cw;
  endfunction
  function automatic int off_pos_z(input int cw);
    return 2 * cw;
  endfunction
  function automatic int off_dir_x(input int cw, input int zw);
    return 2 * cw + zw;
  endfunction
  function automatic int off_dir_y(input int cw, input int zw, input int dw);
    return 2 * cw + zw + dw;
  endfunction

  // round(2^frac * cos(pi/2 * i / n)) for 0 <= i <= n, evaluated with a Q30 Taylor series.
  // Only ever called with constant arguments to fill the quarter-wave table.
  function automatic int q_cos(input int i, input int n, input int frac);
    localparam longint ONE    = 64'sd1 <<< 30;
    localparam longint PI_Q30 = 64'sd3373259426;
    longint x, x2, term, sum;
    x    = (PI_Q30 * longint'(i)) / longint'(2 * n);
    x2   = (x * x) >>> 30;
    term = ONE;
    sum  = ONE;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    return int'(((sum <<< frac) + (ONE >>> 1)) >>> 30);
  endfunction

endpackage

// File: rtl/heading_lut.sv
// heading_lut: heading index -> signed unit direction (cos, sin) via a quarter-wave table.
// Latency: 1 cycle (registered outputs, updated every cycle). Backpressure: none.
// Ports: clk, rst (async active-low), heading in; dir_x = cos, dir_y = sin out. ANGLE_BITS >= 3.
module heading_lut
  import motion_pkg::*;
#(
  parameter int ANGLE_BITS = ANGLE_BITS_DEF,
  parameter int DIR_W      = DIR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ANGLE_BITS-1:0]   heading,
  output logic signed [DIR_W-1:0] dir_x,
  output logic signed [DIR_W-1:0] dir_y
);

  localparam int N  = 1 << (ANGLE_BITS - 2);  // headings per quadrant
  localparam int IW = ANGLE_BITS - 1;         // wide enough to hold 0..N
  localparam logic signed [DIR_W-1:0] ONE = DIR_W'(1 << q_frac(DIR_W));

  logic signed [DIR_W-1:0] tab [0:N];

  for (genvar g = 0; g <= N; g++) begin : g_tab
    localparam logic signed [DIR_W-1:0] V = DIR_W'(q_cos(g, N, q_frac(DIR_W)));
    assign tab[g] = V;
  end

  logic [1:0]              quad;
  logic [IW-1:0]           idx, idx_c;
  logic signed [DIR_W-1:0] a, b;
  logic signed [DIR_W-1:0] dir_x_d, dir_y_d, dir_x_q, dir_y_q;

  // a = cos(offset within quadrant), b = sin(offset) = cos(quarter - offset).
  always_comb begin
    quad  = heading[ANGLE_BITS-1 -: 2];
    idx   = {1'b0, heading[ANGLE_BITS-3:0]};
    idx_c = IW'(N) - idx;
    a     = tab[idx];
    b     = tab[idx_c];
    case (quad)
      2'd0:    begin dir_x_d = a;  dir_y_d = b;  end
      2'd1:    begin dir_x_d = -b; dir_y_d = a;  end
      2'd2:    begin dir_x_d = -a; dir_y_d = -b; end
      default: begin dir_x_d = b;  dir_y_d = -a; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_x_q <= ONE;
      dir_y_q <= '0;
    end else begin
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign dir_x = dir_x_q;
  assign dir_y = dir_y_q;

endmodule

// File: rtl/motion_host.sv
// motion_host: frame-synchronous player/camera engine; rotates, looks up view direction,
// steps and clamps position, then publishes one coherent record per frame_tick.
// Latency: 5 cycles tick->upd_valid. Backpressure: none; ticks while busy are dropped and flag overrun.
// Ports: clk, rst (async active-low), frame_tick/rotate/move/en in; pos_*, dir_*, heading, out_bus,
// upd_valid, busy, overrun out. Macro MOTION_HOST_ACCEL_EN enables hold-to-accelerate stepping.
module motion_host
  import motion_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int Z_W        = Z_W_DEF,
  parameter int DIR_W      = DIR_W_DEF,
  parameter int ANGLE_BITS = ANGLE_BITS_DEF,
  parameter int MOVE_STEP  = 4,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 4095,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 4095,
  parameter int X_INIT     = 2048,
  parameter int Y_INIT     = 2048,
  parameter int Z_INIT     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_tick,
  input  logic [1:0]                            rotate,
  input  logic [1:0]                            move,
  input  logic [3:0]                            en,
  output logic [COORD_W-1:0]                    pos_x,
  output logic [COORD_W-1:0]                    pos_y,
  output logic [Z_W-1:0]                        pos_z,
  output logic signed [DIR_W-1:0]               dir_x,
  output logic signed [DIR_W-1:0]               dir_y,
  output logic [ANGLE_BITS-1:0]                 heading,
  output logic [2*COORD_W+Z_W+2*DIR_W-1:0]      out_bus,
  output logic                                  upd_valid,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int SW = COORD_W + 2;  // signed working width for position sums
  localparam int QF = q_frac(DIR_W);
  localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
  localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] YMIN_S = SW'(Y_MIN);
  localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

  state_e                  state_q, state_d;
  logic [1:0]              rot_q, rot_d, mv_q, mv_d;
  logic [3:0]              en_q, en_d;
  logic [ANGLE_BITS-1:0]   hd_q, hd_d;             // working heading for this frame
  logic signed [SW-1:0]    sx_q, sx_d, sy_q, sy_d; // unclamped stepped position
  logic [COORD_W-1:0]      cx_q, cx_d, cy_q, cy_d; // clamped position awaiting publish
  logic [COORD_W-1:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [Z_W-1:0]          pos_z_q;
  logic signed [DIR_W-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [ANGLE_BITS-1:0]   heading_q, heading_d;
  logic                    upd_valid_q, upd_valid_d, overrun_q, overrun_d;

  logic signed [DIR_W-1:0] lut_x, lut_y;
  logic [1:0]              rot_eff, mv_eff;
  logic [7:0]              step;
  logic signed [31:0]      prod_x, prod_y;
  logic signed [SW-1:0]    dlt_x, dlt_y, base_x, base_y;

  heading_lut #(
    .ANGLE_BITS (ANGLE_BITS),
    .DIR_W      (DIR_W)
  ) u_lut (
    .clk     (clk),
    .rst     (rst),
    .heading (hd_q),
    .dir_x   (lut_x),
    .dir_y   (lut_y)
  );

`ifdef MOTION_HOST_ACCEL_EN
  // Consecutive moving frames; step multiplier is 1 + acc/8, which tops out at 4 for a 5-bit count.
  logic [4:0] acc_q, acc_d;
  always_comb begin
    step  = 8'(MOVE_STEP * (1 + int'(acc_q[4:3])));
    acc_d = acc_q;
    if (state_q == S_STEP) begin
      if (mv_eff == 2'b10 || mv_eff == 2'b01) acc_d = (acc_q == 5'd31) ? acc_q : acc_q + 5'd1;
      else                                    acc_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end
`else
  always_comb step = 8'(MOVE_STEP);
`endif

  always_comb begin
    rot_eff = rot_q & en_q[3:2];
    mv_eff  = mv_q & en_q[1:0];
    // Low product bits are identical for signed/unsigned multiply; the shift is arithmetic (floor).
    prod_x  = 32'(lut_x) * $signed(32'(step));
    prod_y  = 32'(lut_y) * $signed(32'(step));
    dlt_x   = SW'(prod_x >>> QF);
    dlt_y   = SW'(prod_y >>> QF);
    base_x  = {2'b00, pos_x_q};
    base_y  = {2'b00, pos_y_q};
  end

  always_comb begin
    state_d     = state_q;
    rot_d       = rot_q;
    mv_d        = mv_q;
    en_d        = en_q;
    hd_d        = hd_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    heading_d   = heading_q;
    upd_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (frame_tick && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          rot_d   = rotate;
          mv_d    = move;
          en_d    = en;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        case (rot_eff)
          2'b10:   hd_d = heading_q + ANGLE_BITS'(1);
          2'b01:   hd_d = heading_q - ANGLE_BITS'(1);
          default: hd_d = heading_q;
        endcase
        state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_STEP;  // table registers the new heading this cycle
      S_STEP: begin
        case (mv_eff)
          2'b10:   begin sx_d = base_x + dlt_x; sy_d = base_y + dlt_y; end
          2'b01:   begin sx_d = base_x - dlt_x; sy_d = base_y - dlt_y; end
          default: begin sx_d = base_x;         sy_d = base_y;         end
        endcase
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        if (sx_q < XMIN_S)      cx_d = COORD_W'(X_MIN);
        else if (sx_q > XMAX_S) cx_d = COORD_W'(X_MAX);
        else                    cx_d = sx_q[COORD_W-1:0];
        if (sy_q < YMIN_S)      cy_d = COORD_W'(Y_MIN);
        else if (sy_q > YMAX_S) cy_d = COORD_W'(Y_MAX);
        else                    cy_d = sy_q[COORD_W-1:0];
        state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        pos_x_d     = cx_q;
        pos_y_d     = cy_q;
        dir_x_d     = lut_x;
        dir_y_d     = lut_y;
        heading_d   = hd_q;
        upd_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rot_q       <= '0;
      mv_q        <= '0;
      en_q        <= '0;
      hd_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      pos_x_q     <= COORD_W'(X_INIT);
      pos_y_q     <= COORD_W'(Y_INIT);
      pos_z_q     <= Z_W'(Z_INIT);
      dir_x_q     <= DIR_W'(1 << QF);
      dir_y_q     <= '0;
      heading_q   <= '0;
      upd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      mv_q        <= mv_d;
      en_q        <= en_d;
      hd_q        <= hd_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      heading_q   <= heading_d;
      upd_valid_q <= upd_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // out_bus is built only from published registers, so it changes exactly with pos_*/dir_*.
  always_comb begin
    out_bus = '0;
    out_bus[0 +: COORD_W]                           = pos_x_q;
    out_bus[off_pos_y(COORD_W) +: COORD_W]          = pos_y_q;
    out_bus[off_pos_z(COORD_W) +: Z_W]              = pos_z_q;
    out_bus[off_dir_x(COORD_W, Z_W) +: DIR_W]       = dir_x_q;
    out_bus[off_dir_y(COORD_W, Z_W, DIR_W) +: DIR_W] = dir_y_q;
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_z     = pos_z_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign heading   = heading_q;
  assign upd_valid = upd_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_motion_host.sv
// tb_motion_host: directed vectors for motion_host with hand-computed expectations.
// Latency: n/a. Backpressure: n/a.
module tb_motion_host;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_tick = 1'b0;
  logic [1:0]         rotate = '0;
  logic [1:0]         move = '0;
  logic [3:0]         en = '0;
  logic [11:0]        pos_x, pos_y;
  logic [7:0]         pos_z;
  logic signed [9:0]  dir_x, dir_y;
  logic [4:0]         heading;
  logic [51:0]        out_bus;
  logic               upd_valid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;
  int lat, np, nb;

  motion_host dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .rotate     (rotate),
    .move       (move),
    .en         (en),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_z      (pos_z),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .heading    (heading),
    .out_bus    (out_bus),
    .upd_valid  (upd_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // One tick, then observe 10 cycles at negedges: first upd_valid index, pulse count, busy count.
  task automatic run_frame(input logic [1:0] r, input logic [1:0] m, input logic [3:0] e,
                           output int l, output int n, output int b);
    @(negedge clk);
    frame_tick = 1'b1; rotate = r; move = m; en = e;
    @(posedge clk); #1;
    frame_tick = 1'b0; rotate = '0; move = '0; en = '0;
    l = -1; n = 0; b = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (upd_valid) begin n++; if (l < 0) l = i; end
      if (busy) b++;
    end
  endtask

  task automatic test_reset();
    logic [51:0] exp_bus;
    exp_bus = {10'd0, 10'd256, 8'd16, 12'd2048, 12'd2048};
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (pos_x !== 12'd2048) begin miscompares++; $display("FAIL reset_pos_x got %0d exp 2048", pos_x); end
    vectors++; if (pos_y !== 12'd2048) begin miscompares++; $display("FAIL reset_pos_y got %0d exp 2048", pos_y); end
    vectors++; if (pos_z !== 8'd16) begin miscompares++; $display("FAIL reset_pos_z got %0d exp 16", pos_z); end
    vectors++; if (dir_x !== 10'sd256 || dir_y !== 10'sd0) begin miscompares++; $display("FAIL reset_dir got (%0d,%0d) exp (256,0)", dir_x, dir_y); end
    vectors++; if (heading !== 5'd0) begin miscompares++; $display("FAIL reset_heading got %0d exp 0", heading); end
    vectors++; if (upd_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL reset_flags got upd=%b busy=%b ovr=%b exp 000", upd_valid, busy, overrun); end
    vectors++; if (out_bus !== exp_bus) begin miscompares++; $display("FAIL reset_bus got %h exp %h", out_bus, exp_bus); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_move();
    logic [51:0] exp_bus;
    exp_bus = {10'd0, 10'd256, 8'd16, 12'd2048, 12'd2052};
    run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL move_latency got %0d exp 6", lat); end
    vectors++; if (np !== 1) begin miscompares++; $display("FAIL move_pulses got %0d exp 1", np); end
    vectors++; if (nb !== 5) begin miscompares++; $display("FAIL move_busy_cycles got %0d exp 5", nb); end
    vectors++; if (pos_x !== 12'd2052 || pos_y !== 12'd2048) begin miscompares++; $display("FAIL move_pos got (%0d,%0d) exp (2052,2048)", pos_x, pos_y); end
    vectors++; if (out_bus !== exp_bus) begin miscompares++; $display("FAIL move_bus got %h exp %h", out_bus, exp_bus); end
  endtask

  task automatic test_rotate();
    for (int i = 0; i < 8; i++) run_frame(2'b10, 2'b00, 4'b1111, lat, np, nb);
    vectors++; if (heading !== 5'd8) begin miscompares++; $display("FAIL rot_left8_heading got %0d exp 8", heading); end
    vectors++; if (dir_x !== 10'sd0 || dir_y !== 10'sd256) begin miscompares++; $display("FAIL rot_left8_dir got (%0d,%0d) exp (0,256)", dir_x, dir_y); end
    for (int i = 0; i < 8; i++) run_frame(2'b01, 2'b00, 4'b1111, lat, np, nb);
    vectors++; if (heading !== 5'd0 || dir_x !== 10'sd256 || dir_y !== 10'sd0) begin miscompares++; $display("FAIL rot_back0 got h=%0d (%0d,%0d) exp h=0 (256,0)", heading, dir_x, dir_y); end
    run_frame(2'b01, 2'b00, 4'b1111, lat, np, nb);
    vectors++; if (heading !== 5'd31) begin miscompares++; $display("FAIL rot_wrap_down got %0d exp 31", heading); end
    vectors++; if (dir_x !== 10'sd251 || dir_y !== -10'sd50) begin miscompares++; $display("FAIL rot_h31_dir got (%0d,%0d) exp (251,-50)", dir_x, dir_y); end
    run_frame(2'b10, 2'b00, 4'b0111, lat, np, nb);
    vectors++; if (heading !== 5'd31) begin miscompares++; $display("FAIL rot_left_blocked got %0d exp 31", heading); end
    run_frame(2'b11, 2'b00, 4'b1111, lat, np, nb);
    vectors++; if (heading !== 5'd31) begin miscompares++; $display("FAIL rot_both got %0d exp 31", heading); end
  endtask

  // Heading 31: forward delta = (251*4)>>>8 = 3, (-50*4)>>>8 = -1; backward negates both.
  task automatic test_step_dir();
    run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd2055 || pos_y !== 12'd2047) begin miscompares++; $display("FAIL step_fwd_h31 got (%0d,%0d) exp (2055,2047)", pos_x, pos_y); end
    run_frame(2'b00, 2'b01, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd2052 || pos_y !== 12'd2048) begin miscompares++; $display("FAIL step_bwd_h31 got (%0d,%0d) exp (2052,2048)", pos_x, pos_y); end
  endtask

  task automatic test_no_move();
    run_frame(2'b00, 2'b10, 4'b1101, lat, np, nb);
    vectors++; if (pos_x !== 12'd2052 || pos_y !== 12'd2048) begin miscompares++; $display("FAIL nomove_en_pos got (%0d,%0d) exp (2052,2048)", pos_x, pos_y); end
    vectors++; if (np !== 1) begin miscompares++; $display("FAIL nomove_en_pulse got %0d exp 1", np); end
    run_frame(2'b00, 2'b11, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd2052 || pos_y !== 12'd2048) begin miscompares++; $display("FAIL nomove_11_pos got (%0d,%0d) exp (2052,2048)", pos_x, pos_y); end
    vectors++; if (np !== 1) begin miscompares++; $display("FAIL nomove_11_pulse got %0d exp 1", np); end
  endtask

  // 3 forward at h31 -> (2061,2045); heading 0; 508 forward (idle frame every 7 keeps step 4) -> 4093.
  task automatic test_clamp();
    for (int i = 0; i < 3; i++) run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    run_frame(2'b10, 2'b00, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd2061 || pos_y !== 12'd2045 || heading !== 5'd0) begin miscompares++; $display("FAIL clamp_setup got (%0d,%0d) h=%0d exp (2061,2045) h=0", pos_x, pos_y, heading); end
    for (int i = 0; i < 508; i++) begin
      run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
      if (i % 7 == 6) run_frame(2'b00, 2'b00, 4'b1111, lat, np, nb);
    end
    vectors++; if (pos_x !== 12'd4093) begin miscompares++; $display("FAIL clamp_pre got %0d exp 4093", pos_x); end
    run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd4095) begin miscompares++; $display("FAIL clamp_hit got %0d exp 4095", pos_x); end
    run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    vectors++; if (pos_x !== 12'd4095 || pos_y !== 12'd2045) begin miscompares++; $display("FAIL clamp_hold got (%0d,%0d) exp (4095,2045)", pos_x, pos_y); end
  endtask

  // Second tick lands in LOOKUP: dropped, overrun sticks, publish reflects only the first tick.
  task automatic test_back_to_back();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_pre_overrun got %b exp 0", overrun); end
    @(negedge clk);
    frame_tick = 1'b1; rotate = 2'b10; move = 2'b00; en = 4'b1111;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1; rotate = 2'b10; move = 2'b10; en = 4'b1111;
    @(posedge clk); #1;
    frame_tick = 1'b0; rotate = '0; move = '0; en = '0;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (upd_valid) np++;
    end
    vectors++; if (np !== 1) begin miscompares++; $display("FAIL b2b_pulses got %0d exp 1", np); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
    vectors++; if (heading !== 5'd1 || dir_x !== 10'sd251 || dir_y !== 10'sd50) begin miscompares++; $display("FAIL b2b_dir got h=%0d (%0d,%0d) exp h=1 (251,50)", heading, dir_x, dir_y); end
    vectors++; if (pos_x !== 12'd4095 || pos_y !== 12'd2045) begin miscompares++; $display("FAIL b2b_pos got (%0d,%0d) exp (4095,2045)", pos_x, pos_y); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    frame_tick = 1'b1; rotate = 2'b10; move = 2'b10; en = 4'b1111;
    @(posedge clk); #1;
    frame_tick = 1'b0; rotate = '0; move = '0; en = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (pos_x !== 12'd2048 || pos_y !== 12'd2048 || heading !== 5'd0) begin miscompares++; $display("FAIL rstmid_pos got (%0d,%0d) h=%0d exp (2048,2048) h=0", pos_x, pos_y, heading); end
    vectors++; if (dir_x !== 10'sd256 || dir_y !== 10'sd0) begin miscompares++; $display("FAIL rstmid_dir got (%0d,%0d) exp (256,0)", dir_x, dir_y); end
    vectors++; if (busy !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags got busy=%b ovr=%b exp 00", busy, overrun); end
    @(negedge clk);
    rst = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (upd_valid) np++;
    end
    vectors++; if (np !== 0) begin miscompares++; $display("FAIL rstmid_no_publish got %0d pulses exp 0", np); end
    vectors++; if (pos_x !== 12'd2048 || heading !== 5'd0) begin miscompares++; $display("FAIL rstmid_after got x=%0d h=%0d exp x=2048 h=0", pos_x, heading); end
  endtask

  // From reset at heading 0: frames 1..8 step 4; frame 9 steps 8 only with acceleration built in.
  task automatic test_accel();
    int prev, exp_step;
    for (int f = 1; f <= 9; f++) begin
      prev = int'(pos_x);
      run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
`ifdef MOTION_HOST_ACCEL_EN
      exp_step = (f == 9) ? 8 : 4;
`else
      exp_step = 4;
`endif
      vectors++; if (int'(pos_x) - prev !== exp_step) begin miscompares++; $display("FAIL accel_frame%0d step got %0d exp %0d", f, int'(pos_x) - prev, exp_step); end
    end
    run_frame(2'b00, 2'b00, 4'b1111, lat, np, nb);
    prev = int'(pos_x);
    run_frame(2'b00, 2'b10, 4'b1111, lat, np, nb);
    vectors++; if (int'(pos_x) - prev !== 4) begin miscompares++; $display("FAIL accel_after_idle step got %0d exp 4", int'(pos_x) - prev); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_rotate();
    test_step_dir();
    test_no_move();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_accel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
